tnn_input_serializer: RTL and testbench
=======================================

Name: tnn_input_serializer

Overview:
- Upstream feeder for the sequential TNN neuron popcount accumulators.
- Accepts one parallel binary activation vector over a valid/ready handshake.
- Issues a one-cycle accumulator clear, then streams the vector one bit per cycle, LSB first, with a shared enable and input index (cnt). Every popcount instance in the layer consumes these directly.
- Holds a done flag until the downstream consumer acknowledges it has captured the neuron results.

Parameters:
- TOTAL, 4, number of input bits in the layer vector; must be ≥ 1.
- CW, $clog2(TOTAL+1), width of cnt; derived, not overridden.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a vector
- in_data  input  TOTAL  activation vector; bit k is input index k
- hold  input  1  stall request; pauses streaming while high
- acc_clr  output  1  one-cycle clear pulse to downstream accumulators
- enable  output  1  sample/cnt are valid this cycle
- cnt  output  CW  index of the bit currently presented
- sample  output  1  current input bit
- last  output  1  high with enable on the final bit (cnt == TOTAL-1)
- done  output  1  stream complete; results in accumulators are final
- res_ack  input  1  consumer has taken results; releases done

Behaviour:
- Reset: state IDLE; shift register = 0; cnt = 0; enable, sample, last, acc_clr, done = 0; in_ready = 1 (registered).
- Reset mid-operation aborts the stream immediately; no partial done.
- All outputs are registered.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture in_data into the shift register and go to CLEAR.
  - in_ready drops the cycle after acceptance.
- State CLEAR (exactly 1 cycle):
  - acc_clr = 1, enable = 0, cnt = 0.
  - Go to STREAM.
  - hold is ignored in CLEAR.
- State STREAM:
  - When hold = 0: enable = 1, sample = shreg[0], cnt = current index. Next cycle the shift register shifts right by 1 and cnt increments.
  - When hold = 1: enable = 0, sample = 0, cnt and the shift register are frozen. No bit is skipped or duplicated.
  - last = enable & (cnt == TOTAL-1).
  - After the bit with cnt = TOTAL-1 is presented unheld, go to DONE.
- State DONE:
  - done = 1, enable = 0, cnt = TOTAL.
  - done stays high until res_ack = 1. On that cycle go to IDLE; done and in_ready update next cycle.
  - res_ack outside DONE has no effect.
- Timing with no hold, handshake in cycle T:
  - acc_clr in T+1.
  - Bit k presented in T+2+k.
  - done first high in T+2+TOTAL.
  - Minimum turnaround (res_ack in the first done cycle): next acceptance possible in T+4+TOTAL.
- sample is 0 whenever enable = 0.
- cnt never exceeds TOTAL and never wraps.
- TOTAL = 1: STREAM lasts one cycle, with enable and last both high on cnt = 0.
- in_data changes while not in IDLE have no effect.
- in_valid held high across DONE is accepted only after the return to IDLE.

Test Plan:
- Reset, then vector 4'b1011 with TOTAL = 4, no hold -> acc_clr at T+1; (cnt, sample) = (0,1), (1,1), (2,0), (3,1) in T+2..T+5; last only at cnt = 3; done at T+6 with cnt = 4.
- Same vector, hold high for 2 cycles while cnt = 2 -> enable low for 2 cycles, cnt stays 2, then sample 0 at cnt 2 and 1 at cnt 3; done at T+8.
- done held, res_ack low for 5 cycles, in_valid high with a new vector -> in_ready stays 0, done stays 1; after res_ack, the second vector is accepted with a fresh acc_clr pulse.
- Back-to-back vectors 4'b1111 then 4'b0000, each with res_ack in the first done cycle -> sample streams 1,1,1,1 then 0,0,0,0; second acceptance at T+8.
- rst asserted while cnt = 1 -> next edge: enable, done, acc_clr = 0, cnt = 0, in_ready = 1; new vector streams from cnt 0.
- TOTAL = 1, vector 1'b1 -> single enable cycle with cnt = 0, last = 1, sample = 1; done the next cycle with cnt = 1.

Source files
------------

// File: rtl/tnn_input_serializer_if.sv
// Handshake and stream bundle between the activation source, the serializer
// and the popcount accumulators of one TNN layer.
interface tnn_input_serializer_if #(
  parameter int TOTAL = 4
);
  localparam int CW = $clog2(TOTAL + 1);

  logic             in_valid;
  logic             in_ready;
  logic [TOTAL-1:0] in_data;
  logic             hold;
  logic             acc_clr;
  logic             enable;
  logic [CW-1:0]    cnt;
  logic             sample;
  logic             last;
  logic             done;
  logic             res_ack;

  modport master (
    output in_valid, in_data, hold, res_ack,
    input  in_ready, acc_clr, enable, cnt, sample, last, done
  );

  modport slave (
    input  in_valid, in_data, hold, res_ack,
    output in_ready, acc_clr, enable, cnt, sample, last, done
  );
endinterface

// File: rtl/tnn_input_serializer.sv
// Accepts one activation vector, pulses an accumulator clear, then streams the
// vector LSB first with a shared enable/index; holds done until acknowledged.
module tnn_input_serializer #(
  parameter int TOTAL = 4
) (
  input logic                 clk,
  input logic                 rst,
  tnn_input_serializer_if.slave bus
);
  localparam int CW = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FULL_IDX = CW'(TOTAL);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  state_t           state_r;
  logic [TOTAL-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             enable_r;
  logic             sample_r;
  logic             last_r;
  logic             acc_clr_r;
  logic             done_r;
  logic             in_ready_r;

  logic [TOTAL-1:0] sh_next_s;
  logic [CW-1:0]    cnt_next_s;

  assign sh_next_s  = shreg_r >> 1;
  assign cnt_next_s = cnt_r + CW'(1);

  // Control FSM; every output is registered, and hold sampled at an edge
  // decides whether a bit is presented in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      cnt_r      <= '0;
      enable_r   <= 1'b0;
      sample_r   <= 1'b0;
      last_r     <= 1'b0;
      acc_clr_r  <= 1'b0;
      done_r     <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            shreg_r    <= bus.in_data;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            acc_clr_r  <= 1'b1;
            state_r    <= CLEAR;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        CLEAR: begin
          acc_clr_r <= 1'b0;
          enable_r  <= 1'b1;
          sample_r  <= shreg_r[0];
          last_r    <= (LAST_IDX == {CW{1'b0}});
          state_r   <= STREAM;
        end
        STREAM: begin
          if (enable_r) begin
            if (cnt_r == LAST_IDX) begin
              enable_r <= 1'b0;
              sample_r <= 1'b0;
              last_r   <= 1'b0;
              done_r   <= 1'b1;
              cnt_r    <= FULL_IDX;
              state_r  <= DONE;
            end else begin
              // Advance only once the current bit has actually been presented.
              shreg_r  <= sh_next_s;
              cnt_r    <= cnt_next_s;
              enable_r <= !bus.hold;
              sample_r <= !bus.hold && sh_next_s[0];
              last_r   <= !bus.hold && (cnt_next_s == LAST_IDX);
            end
          end else begin
            enable_r <= !bus.hold;
            sample_r <= !bus.hold && shreg_r[0];
            last_r   <= !bus.hold && (cnt_r == LAST_IDX);
          end
        end
        DONE: begin
          if (bus.res_ack) begin
            done_r  <= 1'b0;
            cnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          enable_r   <= 1'b0;
          sample_r   <= 1'b0;
          last_r     <= 1'b0;
          acc_clr_r  <= 1'b0;
          done_r     <= 1'b0;
          cnt_r      <= '0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.acc_clr  = acc_clr_r;
  assign bus.enable   = enable_r;
  assign bus.cnt      = cnt_r;
  assign bus.sample   = sample_r;
  assign bus.last     = last_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_tnn_input_serializer.sv
// Directed bench for tnn_input_serializer: TOTAL=4 instance for the main
// sequences and a TOTAL=1 instance for the single-bit corner case.
module tb_tnn_input_serializer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  tnn_input_serializer_if #(.TOTAL(4)) a ();
  tnn_input_serializer_if #(.TOTAL(1)) b ();

  tnn_input_serializer #(.TOTAL(4)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  tnn_input_serializer #(.TOTAL(1)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Order: in_ready, acc_clr, enable, cnt[2:0], sample, last, done
  task automatic exp4(string tag, logic rdy, logic clr, logic en, logic [2:0] c,
                      logic smp, logic lst, logic dn);
    logic [8:0] o;
    logic [8:0] e;
    o = {a.in_ready, a.acc_clr, a.enable, a.cnt, a.sample, a.last, a.done};
    e = {rdy, clr, en, c, smp, lst, dn};
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, o, e);
  endtask

  task automatic exp1(string tag, logic rdy, logic clr, logic en, logic c,
                      logic smp, logic lst, logic dn);
    logic [6:0] o;
    logic [6:0] e;
    o = {b.in_ready, b.acc_clr, b.enable, b.cnt, b.sample, b.last, b.done};
    e = {rdy, clr, en, c, smp, lst, dn};
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, o, e);
  endtask

  initial begin
    logic [3:0] v;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    a.in_valid = 1'b0; a.in_data = 4'b0000; a.hold = 1'b0; a.res_ack = 1'b0;
    b.in_valid = 1'b0; b.in_data = 1'b0;    b.hold = 1'b0; b.res_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp4("reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    exp1("reset_t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Vector 1011, no hold; in_data scrambled after acceptance
    a.in_valid = 1'b1; a.in_data = 4'b1011;
    step(); a.in_valid = 1'b0; a.in_data = 4'b0000;
    exp4("t1_clr", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); exp4("t1_b0", 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step(); exp4("t1_b1", 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(); exp4("t1_b2", 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    step(); exp4("t1_b3", 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
    step(); exp4("t1_done", 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    a.res_ack = 1'b1;
    step(); a.res_ack = 1'b0;
    exp4("t1_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); exp4("t1_ready", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Same vector with hold high for two cycles ahead of bit 2
    a.in_valid = 1'b1; a.in_data = 4'b1011;
    step(); a.in_valid = 1'b0;
    exp4("t2_clr", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); exp4("t2_b0", 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step(); exp4("t2_b1", 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    a.hold = 1'b1;
    step(); exp4("t2_hold0", 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    step(); exp4("t2_hold1", 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    a.hold = 1'b0;
    step(); exp4("t2_b2", 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    step(); exp4("t2_b3", 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
    step(); exp4("t2_done", 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);

    // done held without res_ack while a new vector waits on in_valid
    a.in_valid = 1'b1; a.in_data = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      step(); exp4("t3_held", 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    end
    a.res_ack = 1'b1;
    step(); a.res_ack = 1'b0;
    exp4("t3_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); exp4("t3_ready", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); a.in_valid = 1'b0;
    exp4("t3_clr", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    v = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      step(); exp4("t3_bit", 1'b0, 1'b0, 1'b1, 3'(k), v[k], (k == 3), 1'b0);
    end
    step(); exp4("t3_done", 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    a.res_ack = 1'b1;
    step(); a.res_ack = 1'b0;
    step(); exp4("t4_ready", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back 1111 then 0000 with minimum turnaround
    a.in_valid = 1'b1; a.in_data = 4'b1111;
    step(); a.in_valid = 1'b0;
    exp4("t4_clr_a", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(); exp4("t4_ones", 1'b0, 1'b0, 1'b1, 3'(k), 1'b1, (k == 3), 1'b0);
    end
    step(); exp4("t4_done_a", 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    a.res_ack = 1'b1; a.in_valid = 1'b1; a.in_data = 4'b0000;
    step(); a.res_ack = 1'b0;
    exp4("t4_gap", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); exp4("t4_accept_b", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); a.in_valid = 1'b0;
    exp4("t4_clr_b", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(); exp4("t4_zeros", 1'b0, 1'b0, 1'b1, 3'(k), 1'b0, (k == 3), 1'b0);
    end
    step(); exp4("t4_done_b", 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    a.res_ack = 1'b1;
    step(); a.res_ack = 1'b0;
    step();

    // Reset mid-stream, then a fresh vector from cnt 0
    a.in_valid = 1'b1; a.in_data = 4'b1010;
    step(); a.in_valid = 1'b0;
    step(); exp4("t5_b0", 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); exp4("t5_b1", 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(); rst = 1'b0;
    exp4("t5_reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    a.in_valid = 1'b1; a.in_data = 4'b0101;
    step(); a.in_valid = 1'b0;
    exp4("t5_clr", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); exp4("t5_n0", 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step(); exp4("t5_n1", 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);

    // TOTAL = 1 instance
    b.in_valid = 1'b1; b.in_data = 1'b1;
    step(); b.in_valid = 1'b0;
    exp1("t6_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); exp1("t6_bit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); exp1("t6_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
